// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: synchronizes the pin vector, detects pin-change and INT0/INT1 events,
// keeps them as sticky W1C pending bits and presents one fixed-priority req/ack interrupt.
module gpio_irq_ctrl #(
  parameter int N_PINS      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_PINS-1:0]   pin_in,
  input  logic [N_PINS-1:0]   pc_mask,
  input  logic [1:0]          int_en,
  input  logic [1:0]          int_mode,
  input  logic                clr_we,
  input  logic [N_PINS+1:0]   clr_data,
  input  logic                clr_ovr,
  input  logic                irq_ack,
  output logic                irq_req,
  output logic [ID_W-1:0]     irq_id,
  output logic [N_PINS+1:0]   pend,
  output logic                overrun
);

  localparam int NB       = N_PINS + 2;
  localparam int INT0_PIN = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOW  = 2'b00,
    MODE_ANY  = 2'b01,
    MODE_FALL = 2'b10,
    MODE_RISE = 2'b11
  } mode_t;

  logic [SYNC_STAGES-1:0][N_PINS-1:0] r_sync;
  logic [N_PINS-1:0]                  r_prev;
  logic [NB-1:0]                      r_pend;
  logic                               r_overrun;
  logic                               r_irq_req;
  logic [ID_W-1:0]                    r_irq_id;
  state_t                             r_state;

  state_t            w_state_nxt;
  logic [ID_W-1:0]   w_irq_id_nxt;
  logic [N_PINS-1:0] w_s;
  logic [N_PINS-1:0] w_chg;
  logic [N_PINS-1:0] w_rise;
  logic [N_PINS-1:0] w_fall;
  logic [NB-1:0]     w_en;
  logic [NB-1:0]     w_set;
  logic [NB-1:0]     w_clr;
  logic [NB-1:0]     w_ack_clr;
  logic [NB-1:0]     w_pend_vis;
  logic [NB-1:0]     w_pend_nxt;
  logic [NB-1:0]     w_ovr_hit;
  logic [ID_W-1:0]   w_winner;
  logic              w_any_pend;
  logic              w_ack_valid;

  // Synchronizer chain: stage 0 samples the pins, the last stage feeds the edge detector.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_chg  = w_s ^ r_prev;
  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;
  assign w_en   = {pc_mask, int_en};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_set = '0;
    for (int k = 0; k < 2; k++) begin
      case (mode_t'(int_mode))
        MODE_LOW:  w_set[k] = ~w_s[INT0_PIN+k];
        MODE_ANY:  w_set[k] = w_chg[INT0_PIN+k];
        MODE_FALL: w_set[k] = w_fall[INT0_PIN+k];
        default:   w_set[k] = w_rise[INT0_PIN+k];
      endcase
    end
    w_set[NB-1:2] = w_chg;
    w_set         = w_set & w_en;
  end

  assign w_ack_valid = (r_state == ST_REQ) && irq_ack;
  assign w_ack_clr   = w_ack_valid ? (NB'(1) << r_irq_id) : '0;
  assign w_clr       = (clr_we ? clr_data : '0) | w_ack_clr;

  // A set in the same cycle as a clear survives; a disabled source is always forced low.
  assign w_pend_nxt = w_en & (w_set | (r_pend & ~w_clr));
  assign w_ovr_hit  = w_set & r_pend & ~w_clr;
  assign w_pend_vis = r_pend & w_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_overrun <= (|w_ovr_hit) | (r_overrun & ~clr_ovr);
    end
  end

  // Lowest id wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_winner = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (w_pend_vis[i]) w_winner = ID_W'(i);
    end
  end

  assign w_any_pend = |w_pend_vis;

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_id_nxt = r_irq_id;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_pend) begin
          w_state_nxt  = ST_REQ;
          w_irq_id_nxt = w_winner;
        end
      end
      ST_REQ: begin
        if (irq_ack)                      w_state_nxt = ST_GAP;
        else if (!w_pend_nxt[r_irq_id])   w_state_nxt = ST_IDLE;
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_irq_req <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_req <= (w_state_nxt == ST_REQ);
      r_irq_id  <= w_irq_id_nxt;
    end
  end

  assign irq_req = r_irq_req;
  assign irq_id  = r_irq_id;
  assign pend    = w_pend_vis;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: a hand-derived vector table, directed corner sequences, and a
// randomized run checked every cycle against a cycle-level behavioural model.
module tb_gpio_irq_ctrl;

  localparam int NP = 16;
  localparam int NB = NP + 2;
  localparam int SS = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NP-1:0]   pin_in = '0;
  logic [NP-1:0]   pc_mask = '0;
  logic [1:0]      int_en = '0;
  logic [1:0]      int_mode = '0;
  logic            clr_we = 1'b0;
  logic [NB-1:0]   clr_data = '0;
  logic            clr_ovr = 1'b0;
  logic            irq_ack = 1'b0;
  logic            irq_req;
  logic [4:0]      irq_id;
  logic [NB-1:0]   pend;
  logic            overrun;

  gpio_irq_ctrl #(.N_PINS(NP), .SYNC_STAGES(SS), .ID_W(5)) dut (
    .clk(clk), .reset(reset), .pin_in(pin_in), .pc_mask(pc_mask), .int_en(int_en),
    .int_mode(int_mode), .clr_we(clr_we), .clr_data(clr_data), .clr_ovr(clr_ovr),
    .irq_ack(irq_ack), .irq_req(irq_req), .irq_id(irq_id), .pend(pend), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NP-1:0] m_hist [0:SS];   // m_hist[0] newest pin sample, m_hist[SS] previous level
  logic [NB-1:0] m_pend;
  bit            m_ovr;
  int            m_phase;         // 0 idle, 1 requesting, 2 gap
  int            m_id;

  task automatic model_reset();
    for (int j = 0; j <= SS; j++) m_hist[j] = '0;
    m_pend  = '0;
    m_ovr   = 0;
    m_phase = 0;
    m_id    = 0;
  endtask

  task automatic model_step();
    logic [NP-1:0] s, p;
    logic [NB-1:0] en, ev, clr, vis, nxt;
    bit hit;
    s  = m_hist[SS-1];
    p  = m_hist[SS];
    en = {pc_mask, int_en};
    ev = '0;
    for (int k = 0; k < 2; k++) begin
      case (int_mode)
        2'b00: ev[k] = (s[14+k] == 1'b0);
        2'b01: ev[k] = (s[14+k] != p[14+k]);
        2'b10: ev[k] = (p[14+k] == 1'b1) && (s[14+k] == 1'b0);
        default: ev[k] = (p[14+k] == 1'b0) && (s[14+k] == 1'b1);
      endcase
    end
    for (int i = 0; i < NP; i++) ev[2+i] = (s[i] != p[i]);
    ev  = ev & en;
    clr = clr_we ? clr_data : '0;
    if (m_phase == 1 && irq_ack) clr[m_id] = 1'b1;
    hit = 0;
    for (int b = 0; b < NB; b++) begin
      if (!en[b]) nxt[b] = 1'b0;
      else if (ev[b]) begin
        nxt[b] = 1'b1;
        if (m_pend[b] && !clr[b]) hit = 1;
      end else nxt[b] = m_pend[b] && !clr[b];
    end
    vis = m_pend & en;
    case (m_phase)
      0: if (vis != 0) begin
           m_phase = 1;
           for (int b = NB - 1; b >= 0; b--) if (vis[b]) m_id = b;
         end
      1: if (irq_ack) m_phase = 2;
         else if (!nxt[m_id]) m_phase = 0;
      default: m_phase = 0;
    endcase
    for (int j = SS; j >= 1; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = pin_in;
    m_ovr  = hit || (m_ovr && !clr_ovr);
    m_pend = nxt;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".req"}, {31'd0, irq_req}, {31'd0, (m_phase == 1)});
    check({tag, ".id"}, {27'd0, irq_id}, m_id);
    check({tag, ".pend"}, {14'd0, pend}, {14'd0, m_pend & {pc_mask, int_en}});
    check({tag, ".ovr"}, {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  // One clock: model advances on the same inputs, outputs compared on the falling edge.
  task automatic tick(input bit cmp = 1'b1);
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (cmp) compare_model("model");
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n;
    n = 0;
    while (irq_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, ".req_seen"}, {31'd0, irq_req}, 32'd1);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst.req", {31'd0, irq_req}, 32'd0);
    check("rst.pend", {14'd0, pend}, 32'd0);
    check("rst.ovr", {31'd0, overrun}, 32'd0);
    check("rst.id", {27'd0, irq_id}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_inputs();
    pin_in = '0; pc_mask = '0; int_en = '0; int_mode = '0;
    clr_we = 1'b0; clr_data = '0; clr_ovr = 1'b0; irq_ack = 1'b0;
  endtask

  typedef struct {
    logic [NP-1:0] pin;
    logic          ack;
    logic          exp_req;
    logic [4:0]    exp_id;
    logic          exp_p5;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin 3 rises before edge 0: pending after edge 2, request after edge 3, ack on edge 5.
    vecs[0] = '{16'h0008, 1'b0, 1'b0, 5'd0, 1'b0};
    vecs[1] = '{16'h0008, 1'b0, 1'b0, 5'd0, 1'b0};
    vecs[2] = '{16'h0008, 1'b0, 1'b0, 5'd0, 1'b1};
    vecs[3] = '{16'h0008, 1'b0, 1'b1, 5'd5, 1'b1};
    vecs[4] = '{16'h0008, 1'b0, 1'b1, 5'd5, 1'b1};
    vecs[5] = '{16'h0008, 1'b1, 1'b0, 5'd5, 1'b0};
    vecs[6] = '{16'h0008, 1'b0, 1'b0, 5'd5, 1'b0};
    vecs[7] = '{16'h0008, 1'b0, 1'b0, 5'd5, 1'b0};

    model_reset();
    clear_inputs();
    @(negedge clk);
    check("t1.reset_req", {31'd0, irq_req}, 32'd0);
    check("t1.reset_pend", {14'd0, pend}, 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    pc_mask = 16'h0008;
    for (int i = 0; i < 8; i++) begin
      pin_in  = vecs[i].pin;
      irq_ack = vecs[i].ack;
      tick(1'b0);
      check($sformatf("t1.req[%0d]", i), {31'd0, irq_req}, {31'd0, vecs[i].exp_req});
      check($sformatf("t1.id[%0d]", i), {27'd0, irq_id}, {27'd0, vecs[i].exp_id});
      check($sformatf("t1.p5[%0d]", i), {31'd0, pend[5]}, {31'd0, vecs[i].exp_p5});
    end
    irq_ack = 1'b0;

    // INT0 falling edge and pin-0 change together: INT0 is served first, then pin 0.
    clear_inputs();
    apply_reset();
    pc_mask = 16'h0001; int_en = 2'b01; int_mode = 2'b10; pin_in = 16'h4000;
    repeat (4) tick();
    check("t2.quiet", {31'd0, irq_req}, 32'd0);
    pin_in = 16'h0001;
    wait_req("t2.first", 8);
    check("t2.id_first", {27'd0, irq_id}, 32'd0);
    pulse_ack();
    check("t2.gap_low", {31'd0, irq_req}, 32'd0);
    wait_req("t2.second", 6);
    check("t2.id_second", {27'd0, irq_id}, 32'd2);
    pulse_ack();

    // INT0 low level re-pends after each ack while the pin stays low.
    clear_inputs();
    apply_reset();
    int_en = 2'b01; int_mode = 2'b00;
    for (int r = 0; r < 3; r++) begin
      wait_req($sformatf("t3.req%0d", r), 8);
      check($sformatf("t3.id%0d", r), {27'd0, irq_id}, 32'd0);
      pulse_ack();
      check($sformatf("t3.repend%0d", r), {31'd0, pend[0]}, 32'd1);
    end
    pin_in = 16'h4000;
    repeat (4) tick();
    wait_req("t3.last", 6);
    pulse_ack();
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("t3.idle%0d", c), {31'd0, irq_req}, 32'd0);
    end

    // Two pin-7 changes without ack raise overrun; clr_ovr drops it.
    clear_inputs();
    apply_reset();
    pc_mask = 16'h0080;
    pin_in  = 16'h0080;
    repeat (5) tick();
    pin_in  = 16'h0000;
    repeat (5) tick();
    check("t4.ovr", {31'd0, overrun}, 32'd1);
    check("t4.p9", {31'd0, pend[9]}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("t4.ovr_clr", {31'd0, overrun}, 32'd0);

    // Withdraw by W1C, then by masking, while requesting id 9.
    check("t5.req", {31'd0, irq_req}, 32'd1);
    check("t5.id", {27'd0, irq_id}, 32'd9);
    clr_we = 1'b1; clr_data = 18'd1 << 9;
    tick();
    clr_we = 1'b0; clr_data = '0;
    check("t5.w1c_withdraw", {31'd0, irq_req}, 32'd0);
    pin_in = 16'h0080;
    wait_req("t5.again", 8);
    check("t5.id_again", {27'd0, irq_id}, 32'd9);
    pc_mask = 16'h0000;
    tick();
    check("t5.mask_withdraw", {31'd0, irq_req}, 32'd0);
    check("t5.mask_p9", {31'd0, pend[9]}, 32'd0);

    // Reset during a request with three bits pending.
    pc_mask = 16'h0007;
    pin_in  = 16'h0087;
    wait_req("t6.req", 8);
    tick();
    check("t6.three", {29'd0, pend[4:2]}, 32'd7);
    pin_in = '0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("t6.quiet%0d", c), {31'd0, irq_req}, 32'd0);
    end

    // Randomized traffic against the model.
    clear_inputs();
    apply_reset();
    pc_mask = 16'hffff; int_en = 2'b11; int_mode = 2'b01;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) pin_in[$urandom_range(0, NP-1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) pin_in[$urandom_range(14, 15)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) pc_mask = 16'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        int_en   = 2'($urandom);
        int_mode = 2'($urandom);
      end
      irq_ack  = (irq_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
      clr_we   = ($urandom_range(0, 9) == 0);
      clr_data = 18'($urandom);
      clr_ovr  = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
